// File: rtl/overdrive_tdm_scheduler.sv
// Round-robin scheduler that shares one combinational overdrive clamp across
// CHANNELS sample sources: accept -> pre-gain -> clamp -> hold result.
module overdrive_tdm_scheduler #(
    parameter int FRAC_W   = 12,
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0]                 i_valid,
    input  logic [CHANNELS*DATA_W-1:0]          i_sample,
    input  logic [CHANNELS*DATA_W-1:0]          i_gain,
    output logic [CHANNELS-1:0]                 o_ready,
    output logic signed [DATA_W-1:0]            clamp_in,
    input  logic signed [DATA_W-1:0]            clamp_out,
    output logic                                o_valid,
    output logic [$clog2(CHANNELS)-1:0]         o_channel,
    output logic signed [DATA_W-1:0]            o_sample,
    input  logic                                i_ready
);

    localparam int CH_W = $clog2(CHANNELS);

    localparam logic signed [2*DATA_W-1:0] SAT_MAX =
        {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] SAT_MIN =
        {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAIN  = 2'd1,
        CLAMP = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Drop the fractional bits (floor) and clip the product back into DATA_W.
    function automatic logic signed [DATA_W-1:0] shift_sat(
        input logic signed [2*DATA_W-1:0] prod
    );
        logic signed [2*DATA_W-1:0] shifted;
        shifted = prod >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            shift_sat = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            shift_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            shift_sat = shifted[DATA_W-1:0];
        end
    endfunction

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                        o_valid_q, o_valid_d;
    logic [CH_W-1:0]             o_channel_q, o_channel_d;
    logic signed [DATA_W-1:0]    o_sample_q, o_sample_d;
    logic signed [DATA_W-1:0]    clamp_in_q, clamp_in_d;

    logic signed [DATA_W-1:0]    sample_q, gain_q;
    logic [CH_W-1:0]             chan_q;

    logic                        found;
    logic [CH_W-1:0]             grant;
    logic [CH_W-1:0]             cand;
    int                          scan_idx;
    logic                        accept;

    logic signed [2*DATA_W-1:0]  sample_x, gain_x, prod;
    logic signed [DATA_W-1:0]    gained;

    // Search upward from rr_ptr, wrapping, for the first requesting channel.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        cand     = '0;
        scan_idx = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= CHANNELS) begin
                scan_idx = scan_idx - CHANNELS;
            end
            cand = CH_W'(scan_idx);
            if (!found && i_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        sample_x = {{DATA_W{sample_q[DATA_W-1]}}, sample_q};
        gain_x   = {{DATA_W{gain_q[DATA_W-1]}}, gain_q};
        prod     = sample_x * gain_x;
        gained   = shift_sat(prod);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        o_valid_d   = o_valid_q;
        o_channel_d = o_channel_q;
        o_sample_d  = o_sample_q;
        clamp_in_d  = clamp_in_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    accept   = 1'b1;
                    rr_ptr_d = (grant == CH_W'(CHANNELS - 1)) ? '0 : grant + CH_W'(1);
                    state_d  = GAIN;
                end
            end
            GAIN: begin
                clamp_in_d = gained;
                state_d    = CLAMP;
            end
            CLAMP: begin
                o_sample_d  = clamp_out;
                o_channel_d = chan_q;
                o_valid_d   = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also forces the accept strobe low so every output reads zero at once.
    assign o_ready = (accept && !rst) ? (CHANNELS'(1) << grant) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            o_valid_q   <= 1'b0;
            o_channel_q <= '0;
            o_sample_q  <= '0;
            clamp_in_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            o_valid_q   <= o_valid_d;
            o_channel_q <= o_channel_d;
            o_sample_q  <= o_sample_d;
            clamp_in_q  <= clamp_in_d;
        end
    end

    // Operands are captured only in the accept cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sample_q <= i_sample[grant*DATA_W +: DATA_W];
            gain_q   <= i_gain[grant*DATA_W +: DATA_W];
            chan_q   <= grant;
        end
    end

    assign clamp_in  = clamp_in_q;
    assign o_valid   = o_valid_q;
    assign o_channel = o_channel_q;
    assign o_sample  = o_sample_q;

endmodule

// File: tb/tb_overdrive_tdm_scheduler.sv
// Directed bench for overdrive_tdm_scheduler with a behavioural soft-clip clamp.
module tb_overdrive_tdm_scheduler;

    localparam int W  = 16;
    localparam int CH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CH-1:0]          i_valid;
    logic [CH*W-1:0]        i_sample;
    logic [CH*W-1:0]        i_gain;
    logic [CH-1:0]          o_ready;
    logic signed [W-1:0]    clamp_in;
    logic signed [W-1:0]    clamp_out;
    logic                   o_valid;
    logic [1:0]             o_channel;
    logic signed [W-1:0]    o_sample;
    logic                   i_ready;

    int checks   = 0;
    int failures = 0;
    int cx, cy;

    overdrive_tdm_scheduler #(
        .FRAC_W(12),
        .DATA_W(W),
        .CHANNELS(CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_sample  (i_sample),
        .i_gain    (i_gain),
        .o_ready   (o_ready),
        .clamp_in  (clamp_in),
        .clamp_out (clamp_out),
        .o_valid   (o_valid),
        .o_channel (o_channel),
        .o_sample  (o_sample),
        .i_ready   (i_ready)
    );

    always #5 clk = ~clk;

    // Soft clip in Q12: y = x - 3/8*x*|x| inside (-1,1), +/-0.5 outside.
    always_comb begin
        cx = int'(clamp_in);
        cy = 0;
        if (cx >= 4096) begin
            cy = 2048;
        end else if (cx <= -4096) begin
            cy = -2048;
        end else begin
            cy = cx - ((3 * cx * ((cx < 0) ? -cx : cx)) >>> 15);
        end
        clamp_out = 16'(cy);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input int s, input int g);
        i_sample[k*W +: W] = 16'(s);
        i_gain[k*W +: W]   = 16'(g);
    endtask

    // One complete transaction on channel k, entered and left in IDLE at posedge+1.
    task automatic run_one(input int k, input int s, input int g,
                           input int exp_ci, input int exp_o);
        set_ch(k, s, g);
        i_valid    = '0;
        i_valid[k] = 1'b1;
        #1;
        chk("grant", o_ready, 1 << k);
        step();
        i_valid = '0;
        set_ch(k, 12345, -1);
        chk("ready_low_gain", o_ready, 0);
        chk("valid_low_gain", o_valid, 0);
        step();
        chk("clamp_in", clamp_in, exp_ci);
        chk("valid_low_clamp", o_valid, 0);
        step();
        chk("valid_t3", o_valid, 1);
        chk("channel", o_channel, k);
        chk("sample", o_sample, exp_o);
        step();
        chk("valid_drop", o_valid, 0);
    endtask

    initial begin
        rst      = 1'b1;
        i_valid  = '0;
        i_sample = '0;
        i_gain   = '0;
        i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_channel", o_channel, 0);
        chk("rst_sample", o_sample, 0);
        chk("rst_clamp_in", clamp_in, 0);
        rst = 1'b0;
        step();

        // Basic clamp path and pre-gain saturation
        run_one(0, 2048, 4096, 2048, 1664);
        run_one(1, -2048, 4096, -2048, -1664);
        run_one(1, 8192, 4096, 8192, 2048);
        run_one(2, 2048, 16384, 8192, 2048);
        run_one(3, 16384, 32767, 32767, 2048);
        run_one(3, -16384, 32767, -32768, -2048);

        // Round robin with every channel requesting, pointer starts at 0
        for (int k = 0; k < CH; k++) set_ch(k, 2048, 4096);
        i_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("rr_grant", o_ready, 1 << (n % 4));
            step();
            chk("rr_ready_gap1", o_ready, 0);
            step();
            chk("rr_ready_gap2", o_ready, 0);
            step();
            chk("rr_valid", o_valid, 1);
            chk("rr_channel", o_channel, n % 4);
            chk("rr_ready_gap3", o_ready, 0);
            step();
        end
        i_valid = '0;

        // Backpressure: pointer is now at 2
        i_ready = 1'b0;
        i_valid = 4'b1100;
        #1;
        chk("bp_grant", o_ready, 4'b0100);
        repeat (3) step();
        chk("bp_valid", o_valid, 1);
        chk("bp_channel", o_channel, 2);
        chk("bp_sample", o_sample, 1664);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("bp_hold_valid", o_valid, 1);
            chk("bp_hold_channel", o_channel, 2);
            chk("bp_hold_sample", o_sample, 1664);
            chk("bp_hold_ready", o_ready, 0);
        end
        i_ready = 1'b1;
        step();
        chk("bp_release_valid", o_valid, 0);
        chk("bp_next_grant", o_ready, 4'b1000);
        i_valid = '0;

        // Reset while a sample sits in CLAMP; pointer 3 wraps to ch0
        set_ch(0, 8192, 4096);
        i_valid = 4'b0001;
        #1;
        chk("pre_rst_grant", o_ready, 4'b0001);
        step();
        i_valid = '0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_clamp_in", clamp_in, 0);
        chk("mid_rst_sample", o_sample, 0);
        chk("mid_rst_channel", o_channel, 0);
        step();
        chk("rst_held_valid", o_valid, 0);
        rst = 1'b0;
        i_valid = 4'b0011;
        #1;
        chk("post_rst_grant", o_ready, 4'b0001);
        step();
        i_valid = '0;
        chk("post_rst_no_valid", o_valid, 0);
        step();
        chk("post_rst_clamp_in", clamp_in, 8192);
        step();
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_channel", o_channel, 0);
        chk("post_rst_sample", o_sample, 2048);
        step();
        chk("post_rst_drop", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
